// File: rtl/smiley_collision_detector_if.sv
// Pixel-scan inputs and per-frame collision report shared between the scan logic and the smiley motion block.
// master drives the scan side and reads the report; slave is the collision detector.
interface smiley_collision_detector_if #(
  parameter int COUNT_W = 12
);
  logic                startOfFrame;
  logic [10:0]         pixelX;
  logic [10:0]         pixelY;
  logic signed [10:0]  topLeftX;
  logic signed [10:0]  topLeftY;
  logic                smileyDR;
  logic                brickDR;
  logic                borderDR;
  logic                collision;
  logic [3:0]          HitEdgeCode;
  logic [COUNT_W-1:0]  overlapCount;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, smileyDR, brickDR, borderDR,
    input  collision, HitEdgeCode, overlapCount
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, smileyDR, brickDR, borderDR,
    output collision, HitEdgeCode, overlapCount
  );
endinterface

// File: rtl/smiley_collision_detector.sv
// Accumulates smiley/brick/border overlap edges over a frame and reports them at the next frame start.
// Pixel-to-accumulator latency 2 cycles; collision pulses 2 cycles after startOfFrame; no backpressure.
module smiley_collision_detector #(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int EDGE_MARGIN   = 4,
  parameter int COUNT_W       = 12
) (
  input  logic                         clk,
  input  logic                         resetN,
  smiley_collision_detector_if.slave   bus
);

  localparam logic signed [11:0] MARGIN     = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_LIM  = 12'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_LIM = 12'(OBJECT_HEIGHT - EDGE_MARGIN);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};

  typedef enum logic {ACCUM, REPORT} state_t;

  logic signed [11:0] pixX12, pixY12, tlX12, tlY12, offX, offY;
  logic               hitNow;
  logic [3:0]         edgeNow;

  logic               hit_r, sof_d;
  logic [3:0]         edge_r;

  logic               accHit;
  logic [3:0]         accCode;
  logic [COUNT_W-1:0] accCount;
  logic [3:0]         hitEdgeCode_r;
  logic [COUNT_W-1:0] overlapCount_r;

  state_t             state_q, state_d;
  logic               collision_c;

  // Offsets are signed so pixels left of / above the sprite origin read as left/top edge.
  assign pixX12 = {1'b0, bus.pixelX};
  assign pixY12 = {1'b0, bus.pixelY};
  assign tlX12  = {bus.topLeftX[10], bus.topLeftX};
  assign tlY12  = {bus.topLeftY[10], bus.topLeftY};
  assign offX   = pixX12 - tlX12;
  assign offY   = pixY12 - tlY12;

  assign hitNow  = bus.smileyDR & (bus.brickDR | bus.borderDR);
  assign edgeNow = hitNow ? {offX < MARGIN, offY < MARGIN, offX >= RIGHT_LIM, offY >= BOTTOM_LIM}
                          : 4'b0000;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_r  <= 1'b0;
      edge_r <= 4'b0000;
      sof_d  <= 1'b0;
    end else begin
      hit_r  <= hitNow;
      edge_r <= edgeNow;
      sof_d  <= bus.startOfFrame;
    end
  end

  // At the frame boundary the accumulators restart from the current stage-1 pixel, so a
  // hit on the startOfFrame pixel belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      accHit         <= 1'b0;
      accCode        <= 4'b0000;
      accCount       <= '0;
      hitEdgeCode_r  <= 4'b0000;
      overlapCount_r <= '0;
    end else if (sof_d) begin
      hitEdgeCode_r  <= accCode;
      overlapCount_r <= accCount;
      accHit         <= hit_r;
      accCode        <= edge_r;
      accCount       <= hit_r ? COUNT_W'(1) : '0;
    end else if (hit_r) begin
      accHit  <= 1'b1;
      accCode <= accCode | edge_r;
      if (accCount != COUNT_MAX) begin
        accCount <= accCount + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    collision_c = 1'b0;
    case (state_q)
      ACCUM: begin
        if (sof_d && accHit) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        collision_c = 1'b1;
        state_d     = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign bus.collision    = collision_c;
  assign bus.HitEdgeCode  = hitEdgeCode_r;
  assign bus.overlapCount = overlapCount_r;

endmodule

// File: tb/tb_smiley_collision_detector.sv
// Directed bench: two detectors (COUNT_W=12 and COUNT_W=4) share one pixel stream; frame reports checked against hand-computed values.
module tb_smiley_collision_detector;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic               sof = 1'b0;
  logic [10:0]        pX = '0, pY = '0;
  logic signed [10:0] tlX = 11'sd100, tlY = 11'sd200;
  logic               sDR = 1'b0, bDR = 1'b0, bdDR = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  smiley_collision_detector_if #(.COUNT_W(12)) ifBig ();
  smiley_collision_detector_if #(.COUNT_W(4))  ifSmall ();

  assign ifBig.startOfFrame   = sof;
  assign ifBig.pixelX         = pX;
  assign ifBig.pixelY         = pY;
  assign ifBig.topLeftX       = tlX;
  assign ifBig.topLeftY       = tlY;
  assign ifBig.smileyDR       = sDR;
  assign ifBig.brickDR        = bDR;
  assign ifBig.borderDR       = bdDR;
  assign ifSmall.startOfFrame = sof;
  assign ifSmall.pixelX       = pX;
  assign ifSmall.pixelY       = pY;
  assign ifSmall.topLeftX     = tlX;
  assign ifSmall.topLeftY     = tlY;
  assign ifSmall.smileyDR     = sDR;
  assign ifSmall.brickDR      = bDR;
  assign ifSmall.borderDR     = bdDR;

  smiley_collision_detector #(.COUNT_W(12)) dutBig (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifBig)
  );

  smiley_collision_detector #(.COUNT_W(4)) dutSmall (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifSmall)
  );

  task automatic check(input string tag, input string what, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic s, input logic b,
                       input logic bd, input logic so);
    @(negedge clk);
    pX = x; pY = y; sDR = s; bDR = b; bdDR = bd; sof = so;
  endtask

  task automatic idle();
    drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic brick_px(input int x, input int y);
    drive(11'(x), 11'(y), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // startOfFrame (optionally with a coincident pixel), then check the report window.
  task automatic frame_end(input string tag, input logic [10:0] x, input logic [10:0] y, input logic s,
                           input logic b, input logic expCol, input logic [3:0] expCode,
                           input logic [11:0] expCnt, input logic [3:0] expCntS);
    drive(x, y, s, b, 1'b0, 1'b1);
    idle();
    check(tag, "col_early", {15'd0, ifBig.collision}, 16'd0);
    idle();
    check(tag, "col",   {15'd0, ifBig.collision},   {15'd0, expCol});
    check(tag, "colS",  {15'd0, ifSmall.collision}, {15'd0, expCol});
    check(tag, "code",  {12'd0, ifBig.HitEdgeCode}, {12'd0, expCode});
    check(tag, "cnt",   {4'd0, ifBig.overlapCount}, {4'd0, expCnt});
    check(tag, "cntS",  {12'd0, ifSmall.overlapCount}, {12'd0, expCntS});
    idle();
    check(tag, "col_fall", {15'd0, ifBig.collision}, 16'd0);
  endtask

  initial begin
    // Reset held with a hit on the bus
    resetN = 1'b0;
    for (int i = 0; i < 5; i++) brick_px(110, 230);
    check("reset", "col",  {15'd0, ifBig.collision}, 16'd0);
    check("reset", "code", {12'd0, ifBig.HitEdgeCode}, 16'd0);
    check("reset", "cnt",  {4'd0, ifBig.overlapCount}, 16'd0);
    idle();
    resetN = 1'b1;
    idle();
    frame_end("post_reset", 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 12'd0, 4'd0);

    // Bottom edge
    brick_px(110, 230);
    idle();
    frame_end("bottom", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b0001, 12'd1, 4'd1);

    // Left+bottom and right+bottom corners in one frame
    brick_px(101, 230);
    brick_px(130, 231);
    idle();
    frame_end("corner", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b1011, 12'd2, 4'd2);

    brick_px(101, 230);
    frame_end("single", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b1001, 12'd1, 4'd1);

    // Top edge via border request; smiley-only and brick-only pixels must not count
    drive(11'd115, 11'd201, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(11'd110, 11'd230, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(11'd110, 11'd230, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    frame_end("top", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b0100, 12'd1, 4'd1);

    brick_px(115, 215);
    frame_end("centre", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd1, 4'd1);

    // Negative sprite X: offsets 5 (centre) and 32 (right)
    tlX = -11'sd5;
    brick_px(0, 215);
    brick_px(27, 215);
    frame_end("neg_x", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b0010, 12'd2, 4'd2);
    tlX = 11'sd100;

    // Pixel left of the sprite origin reads as left edge
    brick_px(90, 215);
    frame_end("neg_off", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b1000, 12'd1, 4'd1);

    // Hit coincident with startOfFrame belongs to the next frame
    brick_px(110, 230);
    frame_end("sof_hit_a", 11'd101, 11'd230, 1'b1, 1'b1, 1'b1, 4'b0001, 12'd1, 4'd1);
    frame_end("sof_hit_b", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b1001, 12'd1, 4'd1);

    // Quiet frame after a hit frame
    frame_end("quiet", 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 12'd0, 4'd0);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) brick_px(130, 201);
    idle();
    frame_end("saturate", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'b0110, 12'd20, 4'd15);

    // Reset mid-frame discards the partial frame
    brick_px(101, 201);
    brick_px(130, 231);
    brick_px(115, 215);
    @(negedge clk);
    resetN = 1'b0;
    idle();
    idle();
    check("mid_reset", "code", {12'd0, ifBig.HitEdgeCode}, 16'd0);
    check("mid_reset", "cnt",  {4'd0, ifBig.overlapCount}, 16'd0);
    resetN = 1'b1;
    idle();
    frame_end("after_mid_reset", 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 12'd0, 4'd0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
